// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
//
// Purpose:
//   Round sequencer for an iterative AES datapath with an on-the-fly key
//   expander. It strobes the expander reset, waits one cycle while the key
//   is loaded, and then walks the round index.
//   - Encrypt: rounds 0..NR.
//   - Decrypt: the expander first runs forward for NR cycles to reach the
//     last round key. The controller then walks rounds NR..0 while the
//     expander runs in reverse.
//   The operation ends with a one-cycle FIN state that pulses done.
//
// Parameters:
//   K          key length in bits (128, 192 or 256)
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   start      request a new operation (sampled only in IDLE)
//   decrypt    1 = decrypt, 0 = encrypt (sampled together with start)
//   abort      cancel the operation in progress (no effect in IDLE)
//   ready      controller idle, will accept start
//   kreset     one-cycle reset strobe to the key expander
//   done1      forward expansion finished, expander now runs in reverse
//   done2      freeze strobe to the key expander (high between operations)
//   round      current round index (0 outside ROUND)
//   valid      expander output is the round key for 'round'
//   first      current round is the initial AddRoundKey round
//   last       current round is the final round (no MixColumns)
//   done       single-cycle completion pulse
//   dbg_state  current FSM state encoding, for debug and checkers
//
// Handshake: start is a level qualified by ready. A start is accepted on
// a rising edge where ready=1 and start=1. The operation then runs to
// completion unless abort or reset is seen. No back-pressure is applied
// to the round outputs.
// -----------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int K = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       decrypt,
    input  logic       abort,
    output logic       ready,
    output logic       kreset,
    output logic       done1,
    output logic       done2,
    output logic [3:0] round,
    output logic       valid,
    output logic       first,
    output logic       last,
    output logic       done,
    output logic [2:0] dbg_state
);

    // Last round index: 10, 12 or 14.
    localparam int         NR_INT = K / 32 + 6;
    localparam logic [3:0] NR     = 4'(NR_INT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_PRIME = 3'd2,
        S_FWD   = 3'd3,
        S_ROUND = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t     state_q, state_d;
    // cnt_q does two jobs:
    //   - in FWD it counts the forward-expansion cycles (never exported);
    //   - in ROUND it is the round index.
    logic [3:0] cnt_q, cnt_d;
    logic       mode_q, mode_d;     // latched decrypt flag
    logic       done1_q, done1_d;
    logic       done2_q, done2_d;

    logic       in_round;
    logic       last_hit;
    logic       first_hit;

    // ------------------------------------------------------------------
    // Output decode (shared with next-state logic for the ROUND exit)
    // ------------------------------------------------------------------
    always_comb begin
        in_round  = (state_q == S_ROUND);
        // The final round is at opposite ends of the count for the two
        // modes, and so is the initial AddRoundKey round.
        last_hit  = in_round & (mode_q ? (cnt_q == 4'd0) : (cnt_q == NR));
        first_hit = in_round & (mode_q ? (cnt_q == NR)   : (cnt_q == 4'd0));
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done1_d = done1_q;
        done2_d = done2_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    mode_d  = decrypt;
                    cnt_d   = 4'd0;
                    // Both expander status flags are cleared as the
                    // new operation is loaded.
                    done1_d = 1'b0;
                    done2_d = 1'b0;
                end
            end

            S_LOAD: begin
                state_d = S_PRIME;
            end

            S_PRIME: begin
                cnt_d   = 4'd0;
                state_d = mode_q ? S_FWD : S_ROUND;
            end

            S_FWD: begin
                if (cnt_q == NR - 4'd1) begin
                    // The expander has produced the last round key.
                    // Walk back from NR with the expander reversed.
                    state_d = S_ROUND;
                    cnt_d   = NR;
                    done1_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_ROUND: begin
                if (last_hit) begin
                    state_d = S_FIN;
                    cnt_d   = 4'd0;
                    done2_d = 1'b1;
                end else if (mode_q) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Abort wins over every normal transition except in IDLE.
        // done1 is left as it is, so the expander direction is preserved.
        // done2 freezes the expander.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            mode_d  = mode_q;
            done1_d = done1_q;
            done2_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            mode_q  <= 1'b0;
            done1_q <= 1'b0;
            done2_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done1_q <= done1_d;
            done2_q <= done2_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        ready     = (state_q == S_IDLE);
        kreset    = (state_q == S_LOAD);
        valid     = in_round;
        round     = in_round ? cnt_q : 4'd0;
        first     = first_hit;
        last      = last_hit;
        done      = (state_q == S_FIN);
        done1     = done1_q;
        done2     = done2_q;
        dbg_state = state_q;
    end

    // ------------------------------------------------------------------
    // Structural properties
    // ------------------------------------------------------------------
    a_kreset_one_cycle : assert property (@(posedge clk) disable iff (reset)
        kreset |=> !kreset);

    a_ready_not_valid : assert property (@(posedge clk) disable iff (reset)
        !(ready && valid));

    a_round_range : assert property (@(posedge clk) disable iff (reset)
        valid |-> (round <= NR));

    a_done_one_cycle : assert property (@(posedge clk) disable iff (reset)
        done |=> !done);

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter K, default 128, meaning key length in bits; legal values 128, 192, 256.
REQ-002 SHALL derive NR = K/32 + 6, meaning the last round index: 10, 12 or 14.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a new operation; sampled only when ready=1.
REQ-006 SHALL have port decrypt, input, 1 bit: operation mode, 1 = decrypt, 0 = encrypt; sampled with start.
REQ-007 SHALL have port abort, input, 1 bit: cancel the operation in progress.
REQ-008 SHALL have port ready, output, 1 bit: controller is idle and will accept start.
REQ-009 SHALL have port kreset, output, 1 bit: reset strobe to the key expander.
REQ-010 SHALL have port done1, output, 1 bit: forward key expansion is complete and the expander runs in reverse.
REQ-011 SHALL have port done2, output, 1 bit: freeze strobe for the key expander.
REQ-012 SHALL have port round, output, 4 bits: current round index.
REQ-013 SHALL have port valid, output, 1 bit: the round key on the expander output belongs to round.
REQ-014 SHALL have port first, output, 1 bit: the current round is the initial AddRoundKey round.
REQ-015 SHALL have port last, output, 1 bit: the current round is the final round (no MixColumns).
REQ-016 SHALL have port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-017 SHALL implement the states IDLE, LOAD, PRIME, FWD, ROUND, FIN.
REQ-018 SHALL move IDLE->LOAD on start=1, latching decrypt; ready=1 only in IDLE.
REQ-019 SHALL ignore start outside IDLE.
REQ-020 SHALL assert kreset=1 only in LOAD, for exactly 1 cycle, then go LOAD->PRIME.
REQ-021 SHALL spend 1 cycle in PRIME while the expander loads the key, with valid=0.
REQ-022 SHALL go PRIME->ROUND for encrypt, with round=0, and increment round once per cycle.
REQ-023 SHALL go PRIME->FWD for decrypt, hold valid=0 and done1=0 in FWD, and count exactly NR cycles.
REQ-024 SHALL go FWD->ROUND for decrypt with done1=1 and round=NR from the first ROUND cycle, then decrement round once per cycle.
REQ-025 SHALL keep done1 at 1 until the next LOAD, where it clears to 0; done1 SHALL be 0 for encrypt.
REQ-026 SHALL hold valid=1 in every ROUND cycle and 0 in every other state; each operation SHALL have exactly NR+1 valid cycles.
REQ-027 SHALL assert first = valid & (round==0 for encrypt, round==NR for decrypt).
REQ-028 SHALL assert last = valid & (round==NR for encrypt, round==0 for decrypt).
REQ-029 SHALL go ROUND->FIN in the cycle after last=1; FIN SHALL last 1 cycle with done=1, then go to IDLE.
REQ-030 SHALL assert done2=1 from FIN onward, through IDLE, until the next LOAD, where it clears to 0.
REQ-031 SHALL on abort=1 in any non-IDLE state go to IDLE next cycle with no done pulse, done2=1 and done1 unchanged; abort in IDLE SHALL have no effect.
REQ-032 SHALL give abort priority over normal transitions; start and abort together in IDLE SHALL start the operation.
REQ-033 SHALL hold round at 0 outside ROUND and FWD; in FWD, round SHALL be an internal count and not exported.
REQ-034 SHALL make operation latency 3+NR cycles from start accepted to done for encrypt, and 3+2*NR for decrypt.

Reset
REQ-035 SHALL on reset=1 enter IDLE with ready=1, kreset=0, done1=0, done2=1, round=0, valid=0, first=0, last=0, done=0.
REQ-036 SHALL let reset override abort and start, including mid-operation; the next start after reset SHALL behave as from power-up.

Verification
REQ-037 SHALL cover: K=128 encrypt start -> kreset 1 cycle, valid for rounds 0..10 (11 cycles), first at 0, last at 10, done 13 cycles after start.
REQ-038 SHALL cover: K=256 decrypt -> FWD 14 cycles, done1 rises with round=14, rounds 14..0, done at cycle 31, done1 held afterwards.
REQ-039 SHALL cover: K=192 encrypt with start pulsed during ROUND -> ignored; exactly 13 valid cycles, one done pulse.
REQ-040 SHALL cover: abort at round 5 -> IDLE next cycle, done never pulses, done2=1, a following start completes normally.
REQ-041 SHALL cover: reset during decrypt FWD -> all outputs at REQ-035 values next cycle.
REQ-042 SHALL cover: back-to-back operations, start held high -> second LOAD the cycle after IDLE is reached, done1 cleared there.
